bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system bus (addrData/byteEnables/burstSize/beginTransaction/endTransaction handshake) among up to NUM_MASTERS bus masters. It issues one-hot grants, tracks the owner through a transaction until the slave's end-of-transaction, inserts one turnaround cycle between owners, and reclaims the bus from masters that stall. It sits between the master request lines and the bus multiplexer, whose select is driven by owner_idx_o.

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/bus_arbiter_rr_picker.sv | 29 ++
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and default parameters for the round-robin bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    BUSY       = 2'd2,
    TURNAROUND = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_MASTERS     = 4;
  localparam int DEF_GRANT_TIMEOUT   = 8;
  localparam int DEF_WATCHDOG_CYCLES = 1024;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i,
// wrapping modulo NUM_MASTERS. Holds no state.
module rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          ptr_i,
  output logic [IW-1:0]          winner_o,
  output logic                   found_o
);

  int idx;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_MASTERS;
      if (req_i[idx]) begin
        winner_o = IW'(idx);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with grant timeout and one-cycle turnaround.
// Optional BUSY watchdog enabled by defining BUS_ARBITER_WATCHDOG_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = DEF_NUM_MASTERS,
  parameter int GRANT_TIMEOUT   = DEF_GRANT_TIMEOUT,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_MASTERS-1:0]         request_i,
  output logic [NUM_MASTERS-1:0]         grant_o,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_idx_o,
  output logic                           owner_valid_o,
  input  logic                           bus_beginTransaction_i,
  input  logic                           bus_endTransaction_i,
  input  logic                           bus_error_i,
  output logic                           bus_endTransaction_o,
  output logic                           bus_error_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(GRANT_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(GRANT_TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          owner_idx_q, owner_idx_d;
  logic                   owner_valid_q, owner_valid_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [IW-1:0]          pick_winner;
  logic                   pick_found;
  logic                   owner_req;
  logic                   bus_done;

  rr_picker #(.NUM_MASTERS(NUM_MASTERS), .IW(IW)) u_picker (
    .req_i    (request_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_winner),
    .found_o  (pick_found)
  );

  assign owner_req = request_i[owner_idx_q];
  assign bus_done  = bus_endTransaction_i | bus_error_i;

`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(WATCHDOG_CYCLES);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_pulse_q, wd_pulse_d;
  logic          wd_expire;

  assign wd_expire = (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == BUSY) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WW'(1);
    end
    wd_pulse_d = (state_q == BUSY) && !bus_done && wd_expire;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q   <= '0;
      wd_pulse_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wd_pulse_q <= wd_pulse_d;
    end
  end

  assign bus_endTransaction_o = wd_pulse_q;
  assign bus_error_o          = wd_pulse_q;
`else
  assign bus_endTransaction_o = 1'b0;
  assign bus_error_o          = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      owner_idx_q   <= '0;
      owner_valid_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      owner_idx_q   <= owner_idx_d;
      owner_valid_q <= owner_valid_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  // Begin beats a simultaneous request drop or timeout: the owner has started.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (pick_found) state_d = GRANTED;
      GRANTED: begin
        if (bus_beginTransaction_i)  state_d = BUSY;
        else if (!owner_req)         state_d = TURNAROUND;
        else if (to_cnt_q == TO_LAST) state_d = TURNAROUND;
      end
      BUSY: begin
        if (bus_done) state_d = TURNAROUND;
`ifdef BUS_ARBITER_WATCHDOG_EN
        else if (wd_expire) state_d = TURNAROUND;
`endif
      end
      TURNAROUND: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    owner_idx_d   = owner_idx_q;
    owner_valid_d = owner_valid_q;
    rr_ptr_d      = rr_ptr_q;
    to_cnt_d      = '0;
    if (state_q == GRANTED) begin
      to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);
    end
    if (state_q == IDLE && pick_found) begin
      grant_d       = NUM_MASTERS'(1) << pick_winner;
      owner_idx_d   = pick_winner;
      owner_valid_d = 1'b1;
      rr_ptr_d      = (pick_winner == IW'(NUM_MASTERS - 1)) ? '0 : pick_winner + IW'(1);
    end
    if (state_d == TURNAROUND) begin
      grant_d       = '0;
      owner_valid_d = 1'b0;
    end
  end

  assign grant_o       = grant_q;
  assign owner_idx_o   = owner_idx_q;
  assign owner_valid_o = owner_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed table-driven bench for bus_arbiter (4 masters, timeout 8, watchdog 16).
// Watchdog expectations follow BUS_ARBITER_WATCHDOG_EN.
module tb_bus_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] request_i = '0;
  logic       beg_i = 1'b0, end_i = 1'b0, err_i = 1'b0;
  logic [3:0] grant_o;
  logic [1:0] owner_idx_o;
  logic       owner_valid_o, end_o, err_o;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.NUM_MASTERS(4), .GRANT_TIMEOUT(8), .WATCHDOG_CYCLES(16)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .request_i              (request_i),
    .grant_o                (grant_o),
    .owner_idx_o            (owner_idx_o),
    .owner_valid_o          (owner_valid_o),
    .bus_beginTransaction_i (beg_i),
    .bus_endTransaction_i   (end_i),
    .bus_error_i            (err_i),
    .bus_endTransaction_o   (end_o),
    .bus_error_o            (err_o)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       beg;
    logic       endt;
    logic       err;
    logic [3:0] eg;
    logic       ev;
    logic [1:0] ei;
    logic       eo;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_no   = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] req, input logic b,
                              input logic e, input logic er, input logic [3:0] eg,
                              input logic ev, input logic [1:0] ei, input logic eo);
    vec_t v;
    v.rst = r; v.req = req; v.beg = b; v.endt = e; v.err = er;
    v.eg = eg; v.ev = ev; v.ei = ei; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, vec_no, act, exp);
    end
  endtask

  task automatic check_outs(input vec_t v);
    chk("grant", 32'(grant_o), 32'(v.eg));
    chk("owner_valid", 32'(owner_valid_o), 32'(v.ev));
    if (v.ev) chk("owner_idx", 32'(owner_idx_o), 32'(v.ei));
    chk("end_o", 32'(end_o), 32'(v.eo));
    chk("err_o", 32'(err_o), 32'(v.eo));
  endtask

  task automatic run_vec(input vec_t v);
    rst_i = v.rst; request_i = v.req; beg_i = v.beg; end_i = v.endt; err_i = v.err;
    @(posedge clk_i);
    #1;
    $display("vec %0d rst=%b req=%b beg=%b end=%b err=%b -> grant=%b valid=%b idx=%0d eo=%b ero=%b",
             vec_no, v.rst, v.req, v.beg, v.endt, v.err, grant_o, owner_valid_o,
             owner_idx_o, end_o, err_o);
    check_outs(v);
    vec_no++;
  endtask

  initial begin
    int m;
    logic [3:0] oh;

    // Single request, begin, end three cycles later.
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 1, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 4'b0100, 1, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 1, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 1, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 2'd0, 0));
    // Synchronous-looking reset pulse, then full round-robin rotation from pointer 0.
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    for (int k = 0; k < 5; k++) begin
      m  = k % 4;
      oh = 4'b0001 << m;
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, oh, 1, 2'(m), 0));
      if (m == 3) vecs.push_back(mk(0, 4'hF, 0, 1, 0, oh, 1, 2'(m), 0));
      vecs.push_back(mk(0, 4'hF, 1, 0, 0, oh, 1, 2'(m), 0));
      vecs.push_back(mk(0, 4'hF, 0, (m != 1), (m >= 1), 4'b0000, 0, 2'd0, 0));
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    end
    // Grant timeout for master 1, then master 2 is served.
    vecs.push_back(mk(0, 4'b0110, 0, 0, 0, 4'b0010, 1, 2'd1, 0));
    for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 4'b0110, 0, 0, 0, 4'b0010, 1, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0110, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0110, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0110, 0, 0, 0, 4'b0100, 1, 2'd2, 0));
    // Owner drops request in GRANTED, then in BUSY.
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 4'b0010, 1, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0010, 1, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0010, 1, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0010, 1, 2'd1, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0));

    repeat (2) @(posedge clk_i);
    #1;
    check_outs(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    rst_i = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stuck transaction: watchdog abort if built in, otherwise the grant holds.
    run_vec(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 1, 2'd0, 0));
    run_vec(mk(0, 4'b0001, 1, 0, 0, 4'b0001, 1, 2'd0, 0));
    for (int j = 1; j <= 17; j++) begin
`ifdef BUS_ARBITER_WATCHDOG_EN
      if (j < 16)       run_vec(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 1, 2'd0, 0));
      else if (j == 16) run_vec(mk(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 2'd0, 1));
      else              run_vec(mk(0, 4'b0001, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
`else
      run_vec(mk(0, 4'b0001, 0, 0, 0, 4'b0001, 1, 2'd0, 0));
`endif
    end
    run_vec(mk(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 2'd0, 0));
    run_vec(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 0));

    // Asynchronous reset mid-BUSY clears outputs before any clock edge.
    run_vec(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 1, 2'd1, 0));
    run_vec(mk(0, 4'b0010, 1, 0, 0, 4'b0010, 1, 2'd1, 0));
    #4;
    rst_i = 1'b1;
    #1;
    $display("async reset asserted -> grant=%b valid=%b idx=%0d", grant_o, owner_valid_o, owner_idx_o);
    chk("async_grant", 32'(grant_o), 32'h0);
    chk("async_valid", 32'(owner_valid_o), 32'h0);
    chk("async_idx", 32'(owner_idx_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    run_vec(mk(0, 4'b1010, 0, 0, 0, 4'b0010, 1, 2'd1, 0));
    run_vec(mk(0, 4'b1010, 1, 0, 0, 4'b0010, 1, 2'd1, 0));
    run_vec(mk(0, 4'b1010, 0, 1, 0, 4'b0000, 0, 2'd0, 0));
    run_vec(mk(0, 4'b1010, 0, 0, 0, 4'b0000, 0, 2'd0, 0));
    run_vec(mk(0, 4'b1010, 0, 0, 0, 4'b1000, 1, 2'd3, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
